// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port sync-read data memory between the CPU MEM stage and a host port,
// CPU first with a starvation guard that hands the host a grant after MAX_WAIT lost cycles.
module dmem_arbiter #(
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [31:0]       conflict_cnt
);
    localparam int WW = MAX_WAIT > 0 ? $clog2(MAX_WAIT + 1) : 1;

    logic [WW-1:0] wait_cnt;
    logic          owner_q;
    logic          rd_pend_q;
    logic          force_host;

    // With MAX_WAIT=0 the compare is always true, giving the host absolute priority.
    assign force_host = host_req & (wait_cnt == WW'(MAX_WAIT));
    assign host_gnt   = ~rst & host_req & (force_host | ~cpu_req);
    assign cpu_gnt    = ~rst & cpu_req & ~host_gnt;
    assign cpu_stall  = ~rst & cpu_req & ~cpu_gnt;
    assign mem_en     = cpu_gnt | host_gnt;

    always_comb begin
        mem_we    = cpu_gnt ? cpu_we    : host_gnt ? host_we    : 1'b0;
        mem_addr  = cpu_gnt ? cpu_addr  : host_gnt ? host_addr  : '0;
        mem_wdata = cpu_gnt ? cpu_wdata : host_gnt ? host_wdata : '0;
    end

    assign cpu_rvalid  = rd_pend_q & ~owner_q;
    assign host_rvalid = rd_pend_q & owner_q;
    assign cpu_rdata   = mem_rdata;
    assign host_rdata  = mem_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt     <= '0;
            owner_q      <= 1'b0;
            rd_pend_q    <= 1'b0;
            conflict_cnt <= '0;
        end else begin
            wait_cnt     <= (host_gnt | ~host_req) ? '0 :
                            (wait_cnt == WW'(MAX_WAIT)) ? wait_cnt : wait_cnt + 1'b1;
            owner_q      <= host_gnt;
            rd_pend_q    <= mem_en & ~mem_we;
            conflict_cnt <= (cpu_req & host_req & ~&conflict_cnt) ? conflict_cnt + 32'd1 : conflict_cnt;
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed and randomized checks of dmem_arbiter against a transaction-level model
module tb_dmem_arbiter;
    localparam int AW = 10;
    localparam int DW = 32;
    localparam int MW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          cpu_req = 0, cpu_we = 0, host_req = 0, host_we = 0;
    logic [AW-1:0] cpu_addr = '0, host_addr = '0;
    logic [DW-1:0] cpu_wdata = '0, host_wdata = '0;
    logic          cpu_gnt, cpu_stall, cpu_rvalid, host_gnt, host_rvalid;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, cpu_rdata, host_rdata;
    logic [DW-1:0] mem_rdata = '0;
    logic [31:0]   conflict_cnt;

    logic          hp_cpu_gnt, hp_cpu_stall, hp_cpu_rvalid, hp_host_gnt, hp_host_rvalid;
    logic          hp_mem_en, hp_mem_we;
    logic [AW-1:0] hp_mem_addr;
    logic [DW-1:0] hp_mem_wdata, hp_cpu_rdata, hp_host_rdata;
    logic [DW-1:0] hp_mem_rdata = '0;
    logic [31:0]   hp_conflict_cnt;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .conflict_cnt(conflict_cnt)
    );

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(0)) hp (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(hp_cpu_gnt), .cpu_stall(hp_cpu_stall), .cpu_rvalid(hp_cpu_rvalid), .cpu_rdata(hp_cpu_rdata),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_gnt(hp_host_gnt), .host_rvalid(hp_host_rvalid), .host_rdata(hp_host_rdata),
        .mem_en(hp_mem_en), .mem_we(hp_mem_we), .mem_addr(hp_mem_addr), .mem_wdata(hp_mem_wdata),
        .mem_rdata(hp_mem_rdata), .conflict_cnt(hp_conflict_cnt)
    );

    // Write-first synchronous memory attached to the main instance.
    logic [DW-1:0] ram [1024];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] = mem_wdata;
            mem_rdata <= ram[mem_addr];
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Transaction-level reference: lost-cycle count, shadow memory, expected read return.
    int            host_lost = 0;
    int unsigned   conf = 0;
    logic [DW-1:0] shadow [1024];
    bit            exp_cv = 0, exp_hv = 0, last_ec = 0, last_eh = 0;
    logic [DW-1:0] exp_rd = '0;

    task automatic model_reset();
        host_lost = 0;
        conf = 0;
        exp_cv = 0;
        exp_hv = 0;
    endtask

    task automatic cyc(input bit c_req, input bit c_we, input logic [AW-1:0] c_a, input logic [DW-1:0] c_d,
                       input bit h_req, input bit h_we, input logic [AW-1:0] h_a, input logic [DW-1:0] h_d);
        bit eh, ec;
        @(negedge clk);
        cpu_req = c_req; cpu_we = c_we; cpu_addr = c_a; cpu_wdata = c_d;
        host_req = h_req; host_we = h_we; host_addr = h_a; host_wdata = h_d;
        #1;
        eh = h_req && (!c_req || host_lost >= MW);
        ec = c_req && !eh;
        chk("cpu_gnt", cpu_gnt, ec);
        chk("host_gnt", host_gnt, eh);
        chk("cpu_stall", cpu_stall, c_req && !ec);
        chk("mem_en", mem_en, ec || eh);
        chk("mem_we", mem_we, ec ? c_we : eh ? h_we : 1'b0);
        chk("mem_addr", mem_addr, ec ? c_a : eh ? h_a : '0);
        chk("mem_wdata", mem_wdata, ec ? c_d : eh ? h_d : '0);
        chk("cpu_rvalid", cpu_rvalid, exp_cv);
        chk("host_rvalid", host_rvalid, exp_hv);
        if (exp_cv) chk("cpu_rdata", cpu_rdata, exp_rd);
        if (exp_hv) chk("host_rdata", host_rdata, exp_rd);
        chk("conflict_cnt", conflict_cnt, conf);
        chk("hp_host_gnt", hp_host_gnt, h_req);
        chk("hp_cpu_gnt", hp_cpu_gnt, c_req && !h_req);
        host_lost = (h_req && !eh) ? ((host_lost + 1 > MW) ? MW : host_lost + 1) : 0;
        if (c_req && h_req) conf++;
        exp_cv = ec && !c_we;
        exp_hv = eh && !h_we;
        if (ec) begin
            if (c_we) shadow[c_a] = c_d;
            else exp_rd = shadow[c_a];
        end
        if (eh) begin
            if (h_we) shadow[h_a] = h_d;
            else exp_rd = shadow[h_a];
        end
        last_ec = ec;
        last_eh = eh;
    endtask

    task automatic idle();
        cyc(0, 0, '0, '0, 0, 0, '0, '0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        cpu_req = 0; host_req = 0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    bit            c_pend, h_pend, c_w, h_w;
    logic [AW-1:0] c_a, h_a;
    logic [DW-1:0] c_d, h_d;

    initial begin
        for (int i = 0; i < 1024; i++) begin
            ram[i] = $urandom;
            shadow[i] = ram[i];
        end
        ram[5] = 32'hDEAD_BEEF;
        shadow[5] = 32'hDEAD_BEEF;
        cpu_req = 1; host_req = 1;
        #2;
        chk("rst_cpu_gnt", cpu_gnt, 0);
        chk("rst_host_gnt", host_gnt, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_stall", cpu_stall, 0);
        @(negedge clk);
        cpu_req = 0; host_req = 0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // Reset arriving while a CPU read is in flight drops the return.
        cyc(1, 0, 10'd5, '0, 1, 0, 10'd9, '0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("t1_cpu_rvalid", cpu_rvalid, 0);
        chk("t1_cpu_gnt", cpu_gnt, 0);
        chk("t1_host_gnt", host_gnt, 0);
        chk("t1_mem_en", mem_en, 0);
        chk("t1_stall", cpu_stall, 0);
        chk("t1_conflict", conflict_cnt, 0);
        @(negedge clk);
        cpu_req = 0; host_req = 0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        idle();
        chk("t1_rvalid_after", cpu_rvalid, 0);

        cyc(1, 0, 10'd5, '0, 0, 0, '0, '0);
        chk("t2_cpu_gnt", cpu_gnt, 1);
        idle();
        chk("t2_cpu_rvalid", cpu_rvalid, 1);
        chk("t2_cpu_rdata", cpu_rdata, 32'hDEAD_BEEF);
        chk("t2_host_rvalid", host_rvalid, 0);

        cyc(0, 0, '0, '0, 1, 1, 10'd7, 32'h1234);
        chk("t3_gnt0", host_gnt, 1);
        cyc(0, 0, '0, '0, 1, 0, 10'd7, '0);
        chk("t3_gnt1", host_gnt, 1);
        idle();
        chk("t3_host_rvalid", host_rvalid, 1);
        chk("t3_host_rdata", host_rdata, 32'h1234);

        pulse_reset();
        for (int i = 0; i < 10; i++) begin
            cyc(1, 0, 10'd1, '0, 1, 0, 10'd2, '0);
            chk("t4_cpu_gnt", cpu_gnt, (i % 5) != 4);
            chk("t4_stall", cpu_stall, (i % 5) == 4);
            if (i < 3) begin
                chk("t5_hp_host_gnt", hp_host_gnt, 1);
                chk("t5_hp_stall", hp_cpu_stall, 1);
            end
        end
        idle();
        chk("t4_conflict", conflict_cnt, 10);

        cyc(1, 1, 10'd3, 32'hA5A5, 0, 0, '0, '0);
        cyc(0, 0, '0, '0, 1, 0, 10'd3, '0);
        idle();
        chk("t6_host_rvalid", host_rvalid, 1);
        chk("t6_host_rdata", host_rdata, 32'hA5A5);

        // Random traffic; each requester holds its request until the model says it was granted.
        c_pend = 0; h_pend = 0;
        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) begin
                pulse_reset();
                c_pend = 0; h_pend = 0;
            end
            if (!c_pend && $urandom_range(3, 0) != 0) begin
                c_pend = 1; c_w = $urandom_range(1, 0) == 1;
                c_a = AW'($urandom_range(15, 0)); c_d = $urandom;
            end
            if (!h_pend && $urandom_range(2, 0) != 0) begin
                h_pend = 1; h_w = $urandom_range(1, 0) == 1;
                h_a = AW'($urandom_range(15, 0)); h_d = $urandom;
            end
            cyc(c_pend, c_w, c_a, c_d, h_pend, h_w, h_a, h_d);
            if (last_ec) c_pend = 0;
            if (last_eh) h_pend = 0;
        end
        idle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
